cond_jump_pc: RTL and testbench
===============================

// Module: cond_jump_pc
// PURPOSE
//   Program-counter stage that consumes the ALU result's sign and zero status.
//   Each valid instruction is evaluated as a conditional jump (LT/EQ/GT mask).
//   The PC loads the jump target when the condition holds; otherwise it increments.
//   Sits between the ALU/less-than-zero logic and the instruction ROM address.
//   Detects a taken self-jump (the halt idiom) and parks the machine in HALTED.
// PARAMETERS
//   WIDTH     16   datapath and PC width
//   COUNT_W   8    width of the taken-jump counter (saturating)
//   RESET_PC  0    PC value loaded on reset
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous, active-high reset
//   instr_valid  in   1        current instruction valid; PC advances only when high
//   jmp_lt       in   1        jump if ALU result < 0
//   jmp_eq       in   1        jump if ALU result == 0
//   jmp_gt       in   1        jump if ALU result > 0
//   alu_x        in   WIDTH    signed ALU result of the current instruction
//   target_a     in   WIDTH    jump target (A register)
//   resume       in   1        leave HALTED; ignored in RUN
//   pc           out  WIDTH    registered program counter
//   jump_taken   out  1        registered 1-cycle pulse: previous update loaded target_a
//   halted       out  1        high while FSM is in HALTED
//   taken_count  out  COUNT_W  number of taken jumps since reset, saturating
// BEHAVIOUR
//   Reset (async, any time, including mid-operation):
//     pc=RESET_PC, jump_taken=0, halted=0, taken_count=0, state=RUN.
//   Condition (combinational, same cycle):
//     lt0  = alu_x[WIDTH-1]
//     zero = (alu_x == 0)
//     gt0  = !lt0 && !zero
//     take = (jmp_lt&lt0) | (jmp_eq&zero) | (jmp_gt&gt0)
//     Mask 3'b111 is an unconditional jump; mask 3'b000 never jumps.
//   FSM states: RUN, HALTED.
//   RUN, instr_valid=1:
//     take=1 -> pc<=target_a, jump_taken<=1, taken_count<=sat(count+1)
//     take=1 and target_a==pc -> additionally go to HALTED (halted<=1, same edge)
//     take=0 -> pc<=pc+1, wraps from all-ones to 0; jump_taken<=0
//   RUN, instr_valid=0: pc, taken_count and state hold; jump_taken<=0.
//   HALTED: pc, taken_count hold; jump_taken<=0; instr_valid and jmp_* ignored.
//     resume=1 -> pc<=pc+1 (wrapping), state<=RUN, halted<=0.
//   resume in RUN: no effect, even when asserted together with instr_valid.
//   taken_count sticks at all-ones; it never wraps.
//   Latency: one clock from instr_valid to the updated pc.
//     No combinational path from any input to any output.
// STRUCTURE
//   Shared package: state encoding (RUN=1'b0, HALTED=1'b1) and jump-mask bit indices
//     (JMP_GT=0, JMP_EQ=1, JMP_LT=2). The ALU and decoder use the same package.
//   One sub-module, jump_condition: combinational (alu_x, mask) -> take.
//     Sign is taken from the MSB only, matching the gate-level less-than-zero logic.
//   Top level holds the PC register, FSM, counter and pulse register.
// TESTING
//   1. Reset, then 4 cycles of instr_valid=1 with mask 000 -> pc 0,1,2,3,4; jump_taken stays 0.
//   2. alu_x=16'h8000, mask LT, target_a=16'h0040 -> pc=0x0040, jump_taken pulses 1 cycle,
//      taken_count=1. Repeat with alu_x=0 under mask LT -> no jump.
//   3. alu_x=0, mask EQ jumps; alu_x=16'h7FFF, mask GT jumps; alu_x=0, mask GT does not.
//   4. pc=0x0010, mask 111, target_a=0x0010 -> halted=1 next edge, pc frozen for 5 cycles;
//      resume=1 -> pc=0x0011, halted=0.
//   5. pc=16'hFFFF, mask 000 -> pc=0x0000. Drive 300 taken jumps -> taken_count=8'hFF.
//   6. Assert rst asynchronously mid-cycle while HALTED with count>0 -> all outputs 0
//      immediately, before the next clock edge.

Source files
------------

// File: rtl/cond_jump_pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cond_jump_pc_pkg
// Description : Shared FSM encoding and jump-mask bit positions for the PC stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_jump_pc_pkg;

   localparam int JMP_GT = 0;
   localparam int JMP_EQ = 1;
   localparam int JMP_LT = 2;

   typedef logic [2:0] jmp_mask_t;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   function automatic jmp_mask_t pack_mask(input logic lt, input logic eq, input logic gt);
      jmp_mask_t m;
      m         = '0;
      m[JMP_LT] = lt;
      m[JMP_EQ] = eq;
      m[JMP_GT] = gt;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cond_jump_pc_if.sv
`default_nettype none
// ============================================================================
// Module      : cond_jump_pc_if
// Description : Instruction/status bundle between the sequencer and the PC stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface cond_jump_pc_if #(
   parameter int WIDTH   = 16,
   parameter int COUNT_W = 8
);
   logic               instr_valid;
   logic               jmp_lt;
   logic               jmp_eq;
   logic               jmp_gt;
   logic [WIDTH-1:0]   alu_x;
   logic [WIDTH-1:0]   target_a;
   logic               resume;
   logic [WIDTH-1:0]   pc;
   logic               jump_taken;
   logic               halted;
   logic [COUNT_W-1:0] taken_count;

   modport master (
      output instr_valid, jmp_lt, jmp_eq, jmp_gt, alu_x, target_a, resume,
      input  pc, jump_taken, halted, taken_count
   );

   modport slave (
      input  instr_valid, jmp_lt, jmp_eq, jmp_gt, alu_x, target_a, resume,
      output pc, jump_taken, halted, taken_count
   );
endinterface
`default_nettype wire

// File: rtl/cond_jump_pc_jump_condition.sv
`default_nettype none
// ============================================================================
// Module      : jump_condition
// Description : Combinational LT/EQ/GT jump decision from the ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
module jump_condition
   import cond_jump_pc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  wire logic [WIDTH-1:0] alu_x,
   input  wire jmp_mask_t        mask,
   output logic                  take
);
   logic w_lt0;
   logic w_zero;
   logic w_gt0;

   // Sign comes from the MSB alone, as the gate-level less-than-zero logic does.
   assign w_lt0  = alu_x[WIDTH-1];
   assign w_zero = (alu_x == '0);
   assign w_gt0  = !w_lt0 && !w_zero;

   assign take = (mask[JMP_LT] & w_lt0)
               | (mask[JMP_EQ] & w_zero)
               | (mask[JMP_GT] & w_gt0);
endmodule
`default_nettype wire

// File: rtl/cond_jump_pc.sv
`default_nettype none
// ============================================================================
// Module      : cond_jump_pc
// Description : Conditional-jump program counter with self-jump halt detection.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_jump_pc
   import cond_jump_pc_pkg::*;
#(
   parameter int               WIDTH    = 16,
   parameter int               COUNT_W  = 8,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input wire logic      clk,
   input wire logic      rst,
   cond_jump_pc_if.slave bus
);
   localparam logic [WIDTH-1:0]   C_PC_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_W-1:0] C_CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   state_t             r_state;
   logic [WIDTH-1:0]   r_pc;
   logic               r_jump_taken;
   logic               r_halted;
   logic [COUNT_W-1:0] r_count;
   jmp_mask_t          w_mask;
   logic               w_take;

   assign w_mask = pack_mask(bus.jmp_lt, bus.jmp_eq, bus.jmp_gt);

   jump_condition #(
      .WIDTH (WIDTH)
   ) u_jump_condition (
      .alu_x (bus.alu_x),
      .mask  (w_mask),
      .take  (w_take)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_RUN;
         r_pc         <= RESET_PC;
         r_jump_taken <= 1'b0;
         r_halted     <= 1'b0;
         r_count      <= '0;
      end else begin
         r_jump_taken <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (bus.instr_valid) begin
                  if (w_take) begin
                     r_pc         <= bus.target_a;
                     r_jump_taken <= 1'b1;
                     if (r_count != '1) begin
                        r_count <= r_count + C_CNT_ONE;
                     end
                     // A taken jump onto itself is the halt idiom.
                     if (bus.target_a == r_pc) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                     end
                  end else begin
                     r_pc <= r_pc + C_PC_ONE;
                  end
               end
            end
            ST_HALTED: begin
               if (bus.resume) begin
                  r_pc     <= r_pc + C_PC_ONE;
                  r_state  <= ST_RUN;
                  r_halted <= 1'b0;
               end
            end
            default: begin
               r_state  <= ST_RUN;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc          = r_pc;
   assign bus.jump_taken  = r_jump_taken;
   assign bus.halted      = r_halted;
   assign bus.taken_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_cond_jump_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_jump_pc
// Description : Self-checking bench: directed vector table, corner sequences, random vs model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_jump_pc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   int   m_pc;
   bit   m_halt;
   int   m_cnt;
   bit   m_jt;

   typedef struct {
      logic        v;
      logic [2:0]  mask;    // {lt, eq, gt}
      logic [15:0] x;
      logic [15:0] t;
      logic        r;
      logic [15:0] e_pc;
      logic        e_jt;
      logic        e_h;
      logic [7:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];

   cond_jump_pc_if #(.WIDTH(16), .COUNT_W(8)) bus ();

   cond_jump_pc #(.WIDTH(16), .COUNT_W(8), .RESET_PC(16'h0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] x,
                        input logic [15:0] t, input logic r);
      bus.instr_valid = v;
      bus.jmp_lt      = m[2];
      bus.jmp_eq      = m[1];
      bus.jmp_gt      = m[0];
      bus.alu_x       = x;
      bus.target_a    = t;
      bus.resume      = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] pc, input logic jt,
                        input logic h, input logic [7:0] c);
      n_checks++;
      if (bus.pc !== pc || bus.jump_taken !== jt || bus.halted !== h || bus.taken_count !== c) begin
         n_fail++;
         $display("FAIL %s: got pc=%h jt=%b halted=%b cnt=%h, expected pc=%h jt=%b halted=%b cnt=%h",
                  name, bus.pc, bus.jump_taken, bus.halted, bus.taken_count, pc, jt, h, c);
      end
   endtask

   function automatic void add(input logic v, input logic [2:0] m, input logic [15:0] x,
                               input logic [15:0] t, input logic r, input logic [15:0] epc,
                               input logic ejt, input logic eh, input logic [7:0] ec);
      vec_t e;
      e.v = v; e.mask = m; e.x = x; e.t = t; e.r = r;
      e.e_pc = epc; e.e_jt = ejt; e.e_h = eh; e.e_cnt = ec;
      vecs.push_back(e);
   endfunction

   // Behavioural model: signed compare on the ALU value, plain integer PC arithmetic.
   task automatic model_step(input logic v, input logic [2:0] m, input logic [15:0] x,
                             input logic [15:0] t, input logic r);
      int  sx;
      bit  take;
      sx = int'($signed(x));
      if (m_halt) begin
         m_jt = 0;
         if (r) begin
            m_pc   = (m_pc + 1) % 65536;
            m_halt = 0;
         end
      end else if (v) begin
         take = (m[2] && sx < 0) || (m[1] && sx == 0) || (m[0] && sx > 0);
         if (take) begin
            m_halt = (int'(t) == m_pc);
            m_pc   = int'(t);
            m_jt   = 1;
            if (m_cnt < 255) m_cnt++;
         end else begin
            m_pc = (m_pc + 1) % 65536;
            m_jt = 0;
         end
      end else begin
         m_jt = 0;
      end
   endtask

   initial begin
      logic [15:0] tgt;
      logic [15:0] rx;
      logic [2:0]  rm;
      logic        rv;
      logic        rr;

      drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
      // Directed vectors: one clock per row, expected outputs after the edge.
      add(1, 3'b000, 16'h0000, 16'h0000, 0, 16'h0001, 0, 0, 8'd0);
      add(1, 3'b000, 16'h0000, 16'h0000, 0, 16'h0002, 0, 0, 8'd0);
      add(1, 3'b000, 16'h0000, 16'h0000, 0, 16'h0003, 0, 0, 8'd0);
      add(1, 3'b000, 16'h0000, 16'h0000, 0, 16'h0004, 0, 0, 8'd0);
      add(1, 3'b100, 16'h8000, 16'h0040, 0, 16'h0040, 1, 0, 8'd1);
      add(0, 3'b100, 16'h8000, 16'h0099, 0, 16'h0040, 0, 0, 8'd1);
      add(1, 3'b100, 16'h0000, 16'h0080, 0, 16'h0041, 0, 0, 8'd1);
      add(1, 3'b010, 16'h0000, 16'h0100, 0, 16'h0100, 1, 0, 8'd2);
      add(1, 3'b001, 16'h7FFF, 16'h0200, 0, 16'h0200, 1, 0, 8'd3);
      add(1, 3'b001, 16'h0000, 16'h0300, 0, 16'h0201, 0, 0, 8'd3);
      add(1, 3'b000, 16'h1234, 16'h0300, 1, 16'h0202, 0, 0, 8'd3);
      add(1, 3'b111, 16'h1234, 16'h0010, 0, 16'h0010, 1, 0, 8'd4);
      add(1, 3'b111, 16'h1234, 16'h0010, 0, 16'h0010, 1, 1, 8'd5);
      for (int i = 0; i < 5; i++)
         add(1, 3'b111, 16'h1234, 16'h0099, 0, 16'h0010, 0, 1, 8'd5);
      add(1, 3'b111, 16'h1234, 16'h0099, 1, 16'h0011, 0, 0, 8'd5);
      add(1, 3'b000, 16'h0000, 16'h0099, 0, 16'h0012, 0, 0, 8'd5);
      add(1, 3'b111, 16'h0001, 16'hFFFF, 0, 16'hFFFF, 1, 0, 8'd6);
      add(1, 3'b000, 16'h0001, 16'h1234, 0, 16'h0000, 0, 0, 8'd6);

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset", 16'h0000, 1'b0, 1'b0, 8'd0);

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].mask, vecs[i].x, vecs[i].t, vecs[i].r);
         tick();
         check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_jt, vecs[i].e_h, vecs[i].e_cnt);
      end

      // Saturation: 300 taken jumps alternating between two non-self targets.
      for (int i = 0; i < 300; i++) begin
         tgt = (i % 2 == 0) ? 16'h1000 : 16'h2000;
         drive(1, 3'b111, 16'h0001, tgt, 0);
         tick();
         if (i == 247) check("count_fe", tgt, 1'b1, 1'b0, 8'hFE);
         if (i == 248) check("count_ff", tgt, 1'b1, 1'b0, 8'hFF);
      end
      check("count_sat", 16'h2000, 1'b1, 1'b0, 8'hFF);

      // Halt, then reset asynchronously before the next edge.
      drive(1, 3'b111, 16'h0001, 16'h2000, 0);
      tick();
      check("halt_again", 16'h2000, 1'b1, 1'b1, 8'hFF);
      drive(0, 3'b000, 16'h0, 16'h0, 0);
      tick();
      #1 rst = 1'b1;
      #1;
      check("async_rst", 16'h0000, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      // Randomized phase against the behavioural model.
      m_pc = 0; m_halt = 0; m_cnt = 0; m_jt = 0;
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0:       rx = 16'h0000;
            1:       rx = 16'h8000;
            2:       rx = 16'h7FFF;
            default: rx = 16'($urandom);
         endcase
         tgt = ($urandom_range(0, 7) == 0) ? 16'(m_pc) : 16'($urandom);
         rm  = 3'($urandom);
         rv  = ($urandom_range(0, 3) != 0);
         rr  = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         drive(rv, rm, rx, tgt, rr);
         model_step(rv, rm, rx, tgt, rr);
         tick();
         check($sformatf("rand%0d", i), 16'(m_pc), m_jt, m_halt, 8'(m_cnt));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
